// File: rtl/spi_input_conditioner.sv
// spi_input_conditioner
// Brings the raw SPI pins (sclk, cs_n, mosi) into the clk domain. Each channel
// has a two-flop synchronizer, a counter-based debouncer and registered
// one-cycle edge pulses. Channel order inside the vectors: 0 = sclk, 1 = cs,
// 2 = mosi.
module spi_input_conditioner #(
   parameter int WAIT_TIME     = 3,
   parameter int COUNTER_WIDTH = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic sclk_in,
   input  logic cs_in,
   input  logic mosi_in,
   output logic sclk_cond,
   output logic sclk_pos,
   output logic sclk_neg,
   output logic cs_cond,
   output logic cs_fall,
   output logic mosi_cond
);

   localparam int NCH = 3;

   // Idle level of each channel: chip select idles high (deselected),
   // sclk and mosi idle low.
   localparam logic [NCH-1:0] IDLE_LEVEL = 3'b010;

   // The last count value before a mismatch is accepted as a real change.
   localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(WAIT_TIME - 1);

   logic [NCH-1:0] pin;
   logic [NCH-1:0] cond;
   logic [NCH-1:0] pos;
   logic [NCH-1:0] neg;

   // The cs rising-edge pulse is produced like every other channel pulse but
   // nothing downstream needs it.
   logic unused_cs_rise;

   assign pin = {mosi_in, cs_in, sclk_in};

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         logic                     sync1;
         logic                     sync2;
         logic [COUNTER_WIDTH-1:0] cnt;
         logic                     level;
         logic                     rise;
         logic                     fall;

         // Two-flop synchronizer for the asynchronous pin.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync1 <= IDLE_LEVEL[gi];
               sync2 <= IDLE_LEVEL[gi];
            end else begin
               sync1 <= pin[gi];
               sync2 <= sync1;
            end
         end

         // Debounce: accept sync2 only after it has disagreed with the
         // conditioned level for WAIT_TIME consecutive cycles; any return to
         // agreement restarts the count. Edge pulses are registered on the
         // same edge that updates the level, so they line up with the first
         // cycle of the new level.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt   <= '0;
               level <= IDLE_LEVEL[gi];
               rise  <= 1'b0;
               fall  <= 1'b0;
            end else begin
               rise <= 1'b0;
               fall <= 1'b0;
               if (sync2 == level) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  level <= sync2;
                  rise  <= sync2;
                  fall  <= ~sync2;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end

         assign cond[gi] = level;
         assign pos[gi]  = rise;
         assign neg[gi]  = fall;
      end
   endgenerate

   assign sclk_cond      = cond[0];
   assign sclk_pos       = pos[0];
   assign sclk_neg       = neg[0];
   assign cs_cond        = cond[1];
   assign cs_fall        = neg[1];
   assign unused_cs_rise = pos[1];
   assign mosi_cond      = cond[2];

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Directed testbench for spi_input_conditioner with default parameters
// (WAIT_TIME = 3). Inputs are driven 1 time unit after a rising edge and
// outputs are sampled at the same point, so a pin change written there is
// seen by the very next edge; the conditioned level then moves on the fifth
// edge after the change.
module tb_spi_input_conditioner;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sclk_in = 1'b0;
   logic cs_in = 1'b1;
   logic mosi_in = 1'b0;
   logic sclk_cond;
   logic sclk_pos;
   logic sclk_neg;
   logic cs_cond;
   logic cs_fall;
   logic mosi_cond;

   int total = 0;
   int passed = 0;
   int failed = 0;

   // SPI byte monitor state
   int       pos_cnt = 0;
   int       neg_cnt = 0;
   int       both_cnt = 0;
   int       fall_cnt = 0;
   logic [7:0] captured = 8'h00;
   logic [7:0] tx_byte = 8'hA5;

   spi_input_conditioner #(
      .WAIT_TIME(3),
      .COUNTER_WIDTH(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sclk_in(sclk_in),
      .cs_in(cs_in),
      .mosi_in(mosi_in),
      .sclk_cond(sclk_cond),
      .sclk_pos(sclk_pos),
      .sclk_neg(sclk_neg),
      .cs_cond(cs_cond),
      .cs_fall(cs_fall),
      .mosi_cond(mosi_cond)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare the packed output vector
   // {sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_fall, mosi_cond}.
   task automatic check(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_fall, mosi_cond};
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic mon_tick();
      tick();
      if (sclk_pos) begin
         pos_cnt++;
         captured = {captured[6:0], mosi_cond};
      end
      if (sclk_neg) neg_cnt++;
      if (sclk_pos && sclk_neg) both_cnt++;
      if (cs_fall) fall_cnt++;
   endtask

   initial begin
      // 1. Reset and idle
      tick();
      tick();
      check("reset_held", 6'b000100);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("idle_%0d", i), 6'b000100);
      end

      // 2. sclk rise then fall
      sclk_in = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("sclk_rise_t%0d", i),
               (i < 5) ? 6'b000100 : ((i == 5) ? 6'b110100 : 6'b100100));
      end
      sclk_in = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("sclk_fall_t%0d", i),
               (i < 5) ? 6'b100100 : ((i == 5) ? 6'b001100 : 6'b000100));
      end

      // 3. cs falls and mosi rises at the same instant
      cs_in   = 1'b0;
      mosi_in = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("cs_mosi_t%0d", i),
               (i < 5) ? 6'b000100 : ((i == 5) ? 6'b000011 : 6'b000001));
      end

      // 4. mosi glitch rejection and minimum accepted pulse
      mosi_in = 1'b0;
      repeat (6) tick();
      check("mosi_low", 6'b000000);
      mosi_in = 1'b1;
      tick();
      tick();
      mosi_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check($sformatf("glitch2_t%0d", i), 6'b000000);
      end
      mosi_in = 1'b1;
      repeat (3) tick();
      mosi_in = 1'b0;
      tick();
      check("pulse3_t4", 6'b000000);
      tick();
      check("pulse3_t5", 6'b000001);
      repeat (10) tick();
      check("pulse3_back", 6'b000000);

      // 5. One SPI byte, mode 0, MSB first, 10-cycle sclk period
      for (int b = 7; b >= 0; b--) begin
         mosi_in = tx_byte[b];
         sclk_in = 1'b0;
         repeat (5) mon_tick();
         sclk_in = 1'b1;
         repeat (5) mon_tick();
      end
      sclk_in = 1'b0;
      repeat (10) mon_tick();
      check_val("byte_pos_count", pos_cnt, 8);
      check_val("byte_neg_count", neg_cnt, 8);
      check_val("byte_data", int'(captured), 32'hA5);
      check_val("byte_pos_neg_overlap", both_cnt, 0);
      check_val("byte_cs_fall", fall_cnt, 0);

      // 6. Reset in the middle of an sclk debounce
      cs_in = 1'b1;
      repeat (10) tick();
      check("deselect", 6'b000101);
      sclk_in = 1'b1;
      repeat (3) tick();
      check("pre_reset", 6'b000101);
      reset = 1'b1;
      #1;
      check("reset_async", 6'b000100);
      tick();
      check("reset_hold1", 6'b000100);
      tick();
      check("reset_hold2", 6'b000100);
      reset = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("post_reset_t%0d", i),
               (i < 5) ? 6'b000100 : ((i == 5) ? 6'b110101 : 6'b100101));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
